fifo_pixel_drain: RTL and testbench

Read-side consumer of the renderer's 48-bit pixel FIFO. It pops one rasterized pixel word at a time from the FIFO read port, computes the framebuffer address, and writes the 16-bit colour into SRAM through a request/acknowledge handshake to the memory arbiter. It runs entirely in the read-clock domain and is the only agent driving the FIFO's read request.

---
 rtl/fifo_pixel_drain_if.sv | 27 ++
 rtl/fifo_pixel_drain.sv | 105 ++++++++++
 tb/tb_fifo_pixel_drain.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/fifo_pixel_drain_if.sv
// Bus bundle between the pixel drain, the renderer FIFO read port and the
// SRAM arbiter. The "master" modport is the drain itself; "slave" is the
// FIFO/arbiter side.
interface fifo_pixel_drain_if;
  logic [47:0] fifo_q;
  logic        fifo_rdempty;
  logic        fifo_rdreq;
  logic [19:0] sram_addr;
  logic [15:0] sram_data;
  logic        sram_req;
  logic        sram_ack;
  logic        busy;
  logic [19:0] pixel_count;
  logic [15:0] dropped_count;

  modport master (
    input  fifo_q, fifo_rdempty, sram_ack,
    output fifo_rdreq, sram_addr, sram_data, sram_req, busy,
           pixel_count, dropped_count
  );

  modport slave (
    output fifo_q, fifo_rdempty, sram_ack,
    input  fifo_rdreq, sram_addr, sram_data, sram_req, busy,
           pixel_count, dropped_count
  );
endinterface

// File: rtl/fifo_pixel_drain.sv
// Pixel FIFO drain: pops one 48-bit pixel word, computes its framebuffer
// address and writes the 16-bit colour to SRAM via req/ack.
// Optional clipping of off-screen pixels is enabled by defining FB_CLIP_EN.
module fifo_pixel_drain #(
  parameter int unsigned WIDTH   = 640,
  parameter int unsigned HEIGHT  = 480,
  parameter logic [19:0] FB_BASE = 20'h00000
) (
  input  logic                 Clk,
  input  logic                 Reset,
  fifo_pixel_drain_if.master   bus
);

  typedef enum logic [1:0] {IDLE, FETCH, CALC, WRITE} state_t;

  state_t      state_q, state_d;
  logic [19:0] sram_addr_q, sram_addr_d;
  logic [15:0] sram_data_q, sram_data_d;
  logic [19:0] pixel_count_q, pixel_count_d;
  logic [15:0] dropped_count_q, dropped_count_d;

  logic [9:0]  pix_x;
  logic [9:0]  pix_y;
  logic [15:0] pix_colour;
  logic [31:0] addr_full;
  logic        clip;
  logic        unused_depth;

  assign pix_x        = bus.fifo_q[47:38];
  assign pix_y        = bus.fifo_q[37:28];
  assign pix_colour   = bus.fifo_q[27:12];
  assign unused_depth = ^bus.fifo_q[11:0];

  // Address is formed at 32 bits and only then truncated to the 20-bit bus.
  assign addr_full = 32'(FB_BASE) + 32'(pix_y) * WIDTH + 32'(pix_x);

`ifdef FB_CLIP_EN
  assign clip = (32'(pix_x) >= WIDTH) || (32'(pix_y) >= HEIGHT);
`else
  logic unused_height;
  assign clip          = 1'b0;
  assign unused_height = ^HEIGHT;
`endif

  // Next-state and datapath update; registers hold by default.
  always_comb begin
    state_d         = state_q;
    sram_addr_d     = sram_addr_q;
    sram_data_d     = sram_data_q;
    pixel_count_d   = pixel_count_q;
    dropped_count_d = dropped_count_q;
    case (state_q)
      IDLE: begin
        if (!bus.fifo_rdempty) state_d = FETCH;
      end
      FETCH: begin
        state_d = CALC;
      end
      CALC: begin
        sram_addr_d = addr_full[19:0];
        sram_data_d = pix_colour;
        if (clip) begin
          state_d = IDLE;
          if (dropped_count_q != '1) dropped_count_d = dropped_count_q + 16'd1;
        end else begin
          state_d = WRITE;
        end
      end
      WRITE: begin
        if (bus.sram_ack) begin
          pixel_count_d = pixel_count_q + 20'd1;
          state_d       = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q         <= IDLE;
      sram_addr_q     <= '0;
      sram_data_q     <= '0;
      pixel_count_q   <= '0;
      dropped_count_q <= '0;
    end else begin
      state_q         <= state_d;
      sram_addr_q     <= sram_addr_d;
      sram_data_q     <= sram_data_d;
      pixel_count_q   <= pixel_count_d;
      dropped_count_q <= dropped_count_d;
    end
  end

  // Strobes are decoded straight from the state register.
  assign bus.fifo_rdreq    = (state_q == FETCH);
  assign bus.sram_req      = (state_q == WRITE);
  assign bus.busy          = (state_q != IDLE);
  assign bus.sram_addr     = sram_addr_q;
  assign bus.sram_data     = sram_data_q;
  assign bus.pixel_count   = pixel_count_q;
  assign bus.dropped_count = dropped_count_q;

endmodule

// File: tb/tb_fifo_pixel_drain.sv
// Directed testbench for fifo_pixel_drain with a FIFO model, an SRAM
// arbiter model with programmable ack delay, and an expected-write queue.
module tb_fifo_pixel_drain;
  localparam int unsigned WIDTH = 640;

  logic Clk   = 1'b0;
  logic Reset = 1'b1;

  fifo_pixel_drain_if ifc();

  fifo_pixel_drain #(.WIDTH(640), .HEIGHT(480), .FB_BASE(20'h00000)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (ifc)
  );

  always #5 Clk = ~Clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [47:0] push_q[$];
  logic [35:0] exp_q[$];
  int unsigned exp_pix  = 0;
  int unsigned exp_drop = 0;
  int          ack_delay = 0;
  bit          ack_en    = 1'b1;
  int          wait_cnt  = 0;
  int          req_run   = 0;
  int          runs[$];
  int          rd_times[$];
  int          cycle     = 0;
  bit          prev_rd   = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // FIFO read-port model: data appears the cycle after a pop strobe.
  always @(posedge Clk) begin
    if (ifc.fifo_rdreq && push_q.size() > 0) ifc.fifo_q <= push_q.pop_front();
    ifc.fifo_rdempty <= (push_q.size() == 0);
  end

  // Arbiter model and scoreboard, sampled on the falling edge.
  always @(negedge Clk) begin
    cycle++;
    if (ifc.fifo_rdreq) begin
      check("rdreq_one_cycle", prev_rd, 1'b0);
      rd_times.push_back(cycle);
    end
    prev_rd = ifc.fifo_rdreq;
    if (ifc.sram_req) begin
      req_run++;
      check("req_has_expected", exp_q.size() != 0, 1'b1);
      if (exp_q.size() != 0) begin
        check("sram_addr", ifc.sram_addr, exp_q[0][35:16]);
        check("sram_data", ifc.sram_data, exp_q[0][15:0]);
      end
      if (ack_en && wait_cnt >= ack_delay) begin
        ifc.sram_ack = 1'b1;
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        exp_pix++;
        wait_cnt = 0;
      end else begin
        ifc.sram_ack = 1'b0;
        wait_cnt++;
      end
    end else begin
      if (req_run > 0) runs.push_back(req_run);
      req_run      = 0;
      ifc.sram_ack = 1'b0;
      wait_cnt     = 0;
    end
  end

  task automatic push_pix(input int x, input int y, input logic [15:0] col, input bit wr);
    int unsigned a;
    push_q.push_back({10'(x), 10'(y), col, 12'($urandom)});
    a = 32'(y) * WIDTH + 32'(x);
    if (wr) exp_q.push_back({a[19:0], col});
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while (!(push_q.size() == 0 && exp_q.size() == 0 && ifc.busy === 1'b0 &&
             ifc.fifo_rdempty === 1'b1) && n < 300) begin
      @(negedge Clk);
      n++;
    end
    check({tag, "_done_in_time"}, n < 300, 1'b1);
    repeat (2) @(negedge Clk);
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;
    @(negedge Clk);
    exp_pix  = 0;
    exp_drop = 0;
    runs.delete();
    rd_times.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    Reset = 1'b1;
    repeat (3) @(negedge Clk);
    check("rst_rdreq", ifc.fifo_rdreq, 0);
    check("rst_req", ifc.sram_req, 0);
    check("rst_busy", ifc.busy, 0);
    check("rst_addr", ifc.sram_addr, 0);
    check("rst_data", ifc.sram_data, 0);
    check("rst_pix", ifc.pixel_count, 0);
    check("rst_drop", ifc.dropped_count, 0);
    Reset = 1'b0;

    // Empty FIFO: nothing happens.
    repeat (20) begin
      @(negedge Clk);
      check("idle_rdreq", ifc.fifo_rdreq, 0);
      check("idle_req", ifc.sram_req, 0);
      check("idle_busy", ifc.busy, 0);
    end

    // Single pixel, immediate ack.
    do_reset();
    ack_delay = 0;
    push_pix(5, 2, 16'hF800, 1'b1);
    drain("single");
    check("single_rdreq_pulses", rd_times.size(), 1);
    check("single_req_runs", runs.size(), 1);
    check("single_req_len", runs.size() > 0 ? runs[0] : 0, 1);
    check("single_addr", ifc.sram_addr, 1285);
    check("single_pix", ifc.pixel_count, exp_pix);

    // Same pixel, ack three cycles late.
    do_reset();
    ack_delay = 3;
    push_pix(5, 2, 16'hF800, 1'b1);
    drain("late");
    check("late_req_runs", runs.size(), 1);
    check("late_req_len", runs.size() > 0 ? runs[0] : 0, 4);
    check("late_pix", ifc.pixel_count, exp_pix);
    check("late_pix_one", exp_pix, 1);

    // Three queued pixels, immediate ack.
    do_reset();
    ack_delay = 0;
    push_pix(0, 0, 16'h001F, 1'b1);
    push_pix(639, 479, 16'h07E0, 1'b1);
    push_pix(100, 200, 16'hABCD, 1'b1);
    drain("burst");
    check("burst_rdreq_pulses", rd_times.size(), 3);
    for (int i = 1; i < 3; i++) begin
      if (rd_times.size() > i) check("burst_rdreq_gap", rd_times[i] - rd_times[i-1], 4);
    end
    check("burst_pix", ifc.pixel_count, exp_pix);
    check("burst_busy", ifc.busy, 0);

    // Off-screen pixels at the right and bottom boundary.
    do_reset();
`ifdef FB_CLIP_EN
    push_pix(640, 0, 16'h1111, 1'b0);
    push_pix(0, 480, 16'h2222, 1'b0);
    exp_drop = 2;
    drain("clip");
    check("clip_req_runs", runs.size(), 0);
`else
    push_pix(640, 0, 16'h1111, 1'b1);
    drain("clip_a");
    check("noclip_addr", ifc.sram_addr, 640);
    push_pix(0, 480, 16'h2222, 1'b1);
    drain("clip_b");
    check("noclip_req_runs", runs.size(), 2);
`endif
    check("clip_pix", ifc.pixel_count, exp_pix);
    check("clip_drop", ifc.dropped_count, exp_drop);

    // Reset while a write is outstanding.
    do_reset();
    ack_en = 1'b0;
    push_pix(7, 3, 16'h1234, 1'b1);
    n = 0;
    while (ifc.sram_req !== 1'b1 && n < 50) begin
      @(negedge Clk);
      n++;
    end
    check("rstw_reach_write", ifc.sram_req, 1);
    repeat (2) @(negedge Clk);
    check("rstw_addr_held", ifc.sram_addr, 1927);
    Reset = 1'b1;
    @(negedge Clk);
    check("rstw_req", ifc.sram_req, 0);
    check("rstw_busy", ifc.busy, 0);
    check("rstw_pix", ifc.pixel_count, 0);
    check("rstw_addr", ifc.sram_addr, 0);
    Reset = 1'b0;
    exp_q.delete();
    ack_en = 1'b1;
    repeat (10) @(negedge Clk);
    check("rstw_never_written", ifc.pixel_count, 0);
    check("rstw_idle", ifc.busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
